// File: rtl/ev_counter_mc.sv
// ev_counter_mc: multi-channel edge-event counter with wrap/saturate overflow; FILTER_DEBOUNCE_EN adds per-channel debounce
module ev_counter_mc #(
   parameter int CH_NUM  = 4,
   parameter int CNT_W   = 32,
   parameter int SAT     = 0,
   parameter int DEB_LEN = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [CH_NUM-1:0] ev_i,
   input  logic [CH_NUM-1:0] en_i,
   input  logic [CH_NUM-1:0] clr_i,
   input  logic [1:0]        mode_i,
   input  logic [3:0]        sel_i,
   output logic [CNT_W-1:0]  cnt_o,
   output logic [CH_NUM-1:0] ovf_o
);
`ifdef FILTER_DEBOUNCE_EN
   localparam int RW = $clog2(DEB_LEN + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(DEB_LEN);
   typedef enum logic {STABLE, PENDING} deb_e;
`endif
   logic [CNT_W-1:0] cnt_a [16];
   for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
      logic s, p_q, ovf_q, ovf_d, strobe, inc;
      logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef FILTER_DEBOUNCE_EN
      deb_e st_q, st_d;
      logic stb_q, stb_d;
      logic [RW-1:0] run_q, run_d;
      // debounce next state: output flips only after the input has differed for DEB_LEN+1 samples
      always_comb begin
         st_d = st_q;
         stb_d = stb_q;
         run_d = run_q;
         if (st_q == STABLE) begin
            if (ev_i[c] != stb_q) begin
               st_d = PENDING;
               run_d = RW'(1);
            end
         end else if (ev_i[c] == stb_q) begin
            st_d = STABLE;
            run_d = '0;
         end else if (run_q == RUN_MAX) begin
            st_d = STABLE;
            stb_d = ~stb_q;
            run_d = '0;
         end else begin
            run_d = run_q + 1'b1;
         end
      end
      // debounce state register
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            st_q <= STABLE;
            stb_q <= 1'b0;
            run_q <= '0;
         end else begin
            st_q <= st_d;
            stb_q <= stb_d;
            run_q <= run_d;
         end
      end
      assign s = stb_q;
`else
      assign s = ev_i[c];
`endif
      assign strobe = mode_i == 2'b01 ? ~s & p_q : mode_i == 2'b10 ? s ^ p_q : s & ~p_q;
      assign inc = strobe & en_i[c];
      // counter next state: clear beats increment; all-ones either wraps or holds, and sets the sticky flag
      always_comb begin
         cnt_d = cnt_q;
         ovf_d = ovf_q;
         if (clr_i[c]) begin
            cnt_d = '0;
            ovf_d = 1'b0;
         end else if (inc) begin
            ovf_d = ovf_q | (&cnt_q);
            cnt_d = (SAT != 0 && (&cnt_q)) ? cnt_q : cnt_q + 1'b1;
         end
      end
      // edge history tracks the input every cycle, independent of enable
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            p_q <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
         end else begin
            p_q <= s;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
         end
      end
      assign cnt_a[c] = cnt_q;
      assign ovf_o[c] = ovf_q;
   end
   for (genvar r = CH_NUM; r < 16; r++) begin : g_pad
      assign cnt_a[r] = '1;
   end
   assign cnt_o = cnt_a[sel_i];
endmodule

// File: doc/ev_counter_mc.md
Name: ev_counter_mc

Overview:
- Multi-channel, parametrised event counter.
- Each channel detects edges on its own event input, with a selectable edge mode, and counts them in its own counter.
- Each counter can wrap or saturate on overflow; each channel keeps a sticky overflow flag and has its own enable and clear.
- Sits between the button/switch front end and the display data mux; one counter value is read at a time through a select index.

Parameters:
- CH_NUM, 4, number of independent channels (1..16).
- CNT_W, 32, counter width in bits (2..32).
- SAT, 0, overflow policy: 0 = wrap to 0, 1 = hold at all-ones.
- DEB_LEN, 4, debounce stable-cycle count (2..255); used only when FILTER_DEBOUNCE_EN is defined.

Ports:
- clk_i  in  1  system clock; all state updates on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high; clears all state.
- ev_i  in  CH_NUM  per-channel event inputs, already synchronous to clk_i.
- en_i  in  CH_NUM  per-channel count enable.
- clr_i  in  CH_NUM  per-channel synchronous clear.
- mode_i  in  2  global edge mode: 00 rising, 01 falling, 10 both edges, 11 rising.
- sel_i  in  4  read channel select.
- cnt_o  out  CNT_W  counter value of the selected channel.
- ovf_o  out  CH_NUM  sticky per-channel overflow flags.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - all counters = 0, ovf_o = 0, edge-history registers = 0, debounce state = 0.
  - Takes effect immediately and holds while rst_i is high, including mid-count.
- Edge detect per channel c:
  - Compare the current input s_c with the registered previous value p_c. s_c is ev_i[c], or the filtered value when debounce is built in.
  - rise = s_c & ~p_c; fall = ~s_c & p_c.
  - The strobe selects rise, fall or rise|fall according to mode_i. p_c <= s_c every cycle, regardless of en_i.
  - Because p_c resets to 0, an input already high on the first cycle after reset counts as a rising edge.
- Count:
  - inc_c = strobe_c & en_i[c]. With en_i low, edges are dropped, not deferred.
  - Latency: an input change seen at clock edge k is reflected in the counter (and cnt_o) after edge k.
- Priority per channel, per cycle:
  - clr_i[c]: counter <= 0 and ovf[c] <= 0. Any simultaneous increment is discarded.
  - Else inc_c with counter < all-ones: counter <= counter + 1.
  - Else inc_c with counter = all-ones:
    - SAT=0: counter <= 0, ovf[c] <= 1.
    - SAT=1: counter holds all-ones, ovf[c] <= 1.
  - ovf[c] stays set until clr_i[c] or reset.
- Channels are fully independent; simultaneous events on all channels all count in the same cycle.
- mode_i change: takes effect the same cycle. p_c is not disturbed, so a mode change alone never creates a strobe.
- Read:
  - cnt_o = counter[sel_i], purely combinational (same-cycle).
  - sel_i >= CH_NUM returns all-ones.
  - ovf_o is the direct register output.
- No internal FSM besides the per-channel debounce FSM below; the block runs continuously after reset.

Optional Feature:
- Macro: FILTER_DEBOUNCE_EN.
- Defined: each channel has a debounce FSM with states STABLE and PENDING, a stable output, and a run counter of width clog2(DEB_LEN+1).
  - STABLE -> PENDING when ev_i differs from the stable output; run counter = 1.
  - In PENDING:
    - input still differs: run counter increments.
    - input returns to the stable value: back to STABLE, run counter = 0.
    - run counter reaches DEB_LEN: stable output flips, FSM -> STABLE.
  - The edge detector sees the stable output. Minimum latency from a clean input edge to the counter update is DEB_LEN+1 cycles.
  - Glitches shorter than DEB_LEN cycles are never counted.
- Undefined: ev_i feeds the edge detector directly; DEB_LEN is ignored and no debounce logic is generated.

Test Plan:
- Reset and rising mode: after reset, mode_i=00, en_i=all 1, 3 pulses on ev_i[0] (2 cycles high / 2 low), sel_i=0 -> cnt_o=3, other channels 0, ovf_o=0; assert rst_i mid-pulse -> cnt_o=0 the same cycle, before the next clock edge.
- Modes: 3 pulses on ev_i[1] with mode_i=01 -> 3; repeat with mode_i=10 after clr_i[1] -> 6; toggle mode_i with ev_i static -> no change.
- Enable and clear: en_i[2]=0 during 2 pulses -> 0; en_i[2]=1, 1 pulse -> 1; clr_i[2] in the same cycle as an edge -> 0, edge discarded.
- Overflow with CNT_W=4: SAT=0, 17 edges -> cnt_o=1, ovf_o[0]=1. SAT=1, 17 edges -> cnt_o=15, ovf_o[0]=1. clr_i[0] -> cnt_o=0, ovf_o[0]=0.
- Parallel channels and select: CH_NUM=4, edges on all channels on the same cycle, 5 times -> sel_i=0..3 each read 5; sel_i=7 -> all-ones.
- FILTER_DEBOUNCE_EN, DEB_LEN=4:
  - 3-cycle glitch -> count unchanged.
  - 6-cycle high pulse -> count +1, appearing 5 cycles after the input edge.
